// File: rtl/timer_input_pkg.sv
// Shared types and constants for the timer-input keypad path and its debounce handshake.
package timer_input_pkg;

  localparam int unsigned NUM_KEYS    = 10;
  localparam int unsigned CODE_W      = 4;
  // Rising edges with db_clear_n high before the debounce counter raises db_edge
  localparam int unsigned DB_EDGE_LAT = 5;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CONFIRM,
    HOLD
  } kde_state_e;

endpackage

// File: rtl/key_onehot_encode.sv
// Combinational keypad decode: single-key detect, index encode, and compare against the captured key.
module key_onehot_encode #(
  parameter int unsigned NUM_KEYS = timer_input_pkg::NUM_KEYS,
  parameter int unsigned CODE_W   = timer_input_pkg::CODE_W
) (
  input  logic [NUM_KEYS-1:0] keys_i,
  input  logic [CODE_W-1:0]   cap_code_i,
  output logic                exactly_one_o,
  output logic [CODE_W-1:0]   code_o,
  output logic                match_o
);

  always_comb begin
    exactly_one_o = (keys_i != '0) && ((keys_i & (keys_i - NUM_KEYS'(1))) == '0);
    code_o        = '0;
    match_o       = 1'b1;
    // match_o is true only when keys_i is exactly the one-hot of cap_code_i
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (keys_i[i]) code_o = CODE_W'(i);
      if (keys_i[i] != (cap_code_i == CODE_W'(i))) match_o = 1'b0;
    end
  end

endmodule

// File: rtl/keypad_debounce_encoder.sv
// Keypad controller: arms the debounce counter on a single-key press, emits one validated
// BCD code per press, and waits for a debounced release before re-arming.
module keypad_debounce_encoder #(
  parameter int unsigned NUM_KEYS       = timer_input_pkg::NUM_KEYS,
  parameter int unsigned CODE_W         = timer_input_pkg::CODE_W,
  parameter int unsigned EDGE_TIMEOUT   = 12,
  parameter int unsigned RELEASE_CYCLES = 4
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                db_edge,
  output logic                db_clear_n,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic                key_busy,
  output logic                db_fault
);
  import timer_input_pkg::*;

  localparam int unsigned TW = $clog2(EDGE_TIMEOUT + 1);
  localparam int unsigned RW = $clog2(RELEASE_CYCLES + 1);

  kde_state_e        state_q, state_d;
  logic [CODE_W-1:0] cap_q, cap_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [TW-1:0]     tmo_q, tmo_d, tmo_inc;
  logic [RW-1:0]     rel_q, rel_d, rel_inc;
  logic              fault_q, fault_d;
  logic              valid_q, clrn_q, busy_q;

  logic              exactly_one;
  logic              match;
  logic [CODE_W-1:0] idx;

  key_onehot_encode #(
    .NUM_KEYS (NUM_KEYS),
    .CODE_W   (CODE_W)
  ) u_enc (
    .keys_i        (keys),
    .cap_code_i    (cap_q),
    .exactly_one_o (exactly_one),
    .code_o        (idx),
    .match_o       (match)
  );

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    code_d  = code_q;
    tmo_d   = tmo_q;
    rel_d   = rel_q;
    fault_d = fault_q;
    tmo_inc = (tmo_q == TW'(EDGE_TIMEOUT)) ? tmo_q : tmo_q + TW'(1);
    if (keys != '0)                     rel_inc = '0;
    else if (rel_q == RW'(RELEASE_CYCLES)) rel_inc = rel_q;
    else                                rel_inc = rel_q + RW'(1);

    unique case (state_q)
      IDLE: begin
        if (exactly_one) begin
          state_d = ARM;
          cap_d   = idx;
          tmo_d   = '0;
        end
      end
      ARM: begin
        tmo_d = tmo_inc;
        // A changed key pattern outranks db_edge so a bounce always restarts debounce
        if (!match) begin
          state_d = IDLE;
        end else if (db_edge) begin
          state_d = CONFIRM;
          code_d  = cap_q;
        end else if (tmo_inc >= TW'(EDGE_TIMEOUT)) begin
          state_d = IDLE;
          fault_d = 1'b1;
        end
      end
      CONFIRM: begin
        state_d = HOLD;
        rel_d   = '0;
      end
      HOLD: begin
        rel_d = rel_inc;
        if (rel_inc >= RW'(RELEASE_CYCLES)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      cap_q   <= '0;
      code_q  <= '0;
      tmo_q   <= '0;
      rel_q   <= '0;
      fault_q <= 1'b0;
      valid_q <= 1'b0;
      clrn_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      code_q  <= code_d;
      tmo_q   <= tmo_d;
      rel_q   <= rel_d;
      fault_q <= fault_d;
      valid_q <= (state_d == CONFIRM);
      clrn_q  <= (state_d == ARM);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign db_clear_n = clrn_q;
  assign key_code   = code_q;
  assign key_valid  = valid_q;
  assign key_busy   = busy_q;
  assign db_fault   = fault_q;

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Bench for keypad_debounce_encoder: directed scenarios plus random key traffic against a press/release model.
module tb_keypad_debounce_encoder;

  localparam int unsigned NK  = 10;
  localparam int unsigned CW  = 4;
  localparam int unsigned TMO = 12;
  localparam int unsigned REL = 4;
  localparam int unsigned LAT = timer_input_pkg::DB_EDGE_LAT;

  logic          clock = 1'b0;
  logic          clear = 1'b1;
  logic [NK-1:0] keys  = '0;
  logic          db_edge;
  logic          db_clear_n;
  logic [CW-1:0] key_code;
  logic          key_valid;
  logic          key_busy;
  logic          db_fault;

  keypad_debounce_encoder #(
    .NUM_KEYS       (NK),
    .CODE_W         (CW),
    .EDGE_TIMEOUT   (TMO),
    .RELEASE_CYCLES (REL)
  ) dut (
    .clock      (clock),
    .clear      (clear),
    .keys       (keys),
    .db_edge    (db_edge),
    .db_clear_n (db_clear_n),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_busy   (key_busy),
    .db_fault   (db_fault)
  );

  always #5 clock = ~clock;

  // Debounce delay counter environment: db_edge after LAT edges with db_clear_n high
  int unsigned db_cnt;
  logic        edge_en = 1'b1;
  always @(posedge clock or posedge clear) begin
    if (clear)            db_cnt <= 0;
    else if (!db_clear_n) db_cnt <= 0;
    else if (db_cnt < LAT) db_cnt <= db_cnt + 1;
  end
  assign db_edge = edge_en && (db_cnt == LAT);

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int n_pulse, t0, t_valid, t_fault;
  logic [CW-1:0] last_code;

  // Reference: press lifecycle tracked as armed/confirming/holding with age and zero-run counts
  bit            m_arm, m_conf, m_hold;
  int            m_age, m_zero, m_key;
  logic          exp_valid, exp_clrn, exp_busy, exp_fault;
  logic [CW-1:0] exp_code;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    m_arm = 0; m_conf = 0; m_hold = 0;
    m_age = 0; m_zero = 0; m_key = 0;
    exp_valid = 0; exp_clrn = 0; exp_busy = 0; exp_fault = 0; exp_code = '0;
  endtask

  task automatic model_step(input logic [NK-1:0] k, input logic e);
    logic [NK-1:0] want_k;
    want_k = NK'(1) << m_key;
    if (m_conf) begin
      m_conf = 0; m_hold = 1; m_zero = 0;
    end else if (m_hold) begin
      m_zero = (k == '0) ? m_zero + 1 : 0;
      if (m_zero >= REL) m_hold = 0;
    end else if (m_arm) begin
      m_age++;
      if (k != want_k) m_arm = 0;
      else if (e) begin
        m_arm = 0; m_conf = 1; exp_code = CW'(m_key);
      end else if (m_age >= TMO) begin
        m_arm = 0; exp_fault = 1;
      end
    end else if ($countones(k) == 1) begin
      m_arm = 1; m_age = 0;
      for (int i = 0; i < NK; i++) if (k[i]) m_key = i;
    end
    exp_valid = m_conf;
    exp_clrn  = m_arm;
    exp_busy  = m_arm | m_conf | m_hold;
  endtask

  task automatic check_outputs();
    chk("key_valid",  key_valid,  exp_valid);
    chk("key_code",   key_code,   exp_code);
    chk("db_clear_n", db_clear_n, exp_clrn);
    chk("key_busy",   key_busy,   exp_busy);
    chk("db_fault",   db_fault,   exp_fault);
  endtask

  task automatic step(input logic [NK-1:0] k);
    logic e;
    @(negedge clock);
    keys = k;
    #1 e = db_edge;
    @(posedge clock);
    #1;
    cyc++;
    model_step(k, e);
    check_outputs();
    if (key_valid) begin
      n_pulse++;
      last_code = key_code;
      if (t_valid == 0) t_valid = cyc;
    end
    if (db_fault && t_fault == 0) t_fault = cyc;
  endtask

  task automatic hold(input logic [NK-1:0] k, input int n);
    for (int i = 0; i < n; i++) step(k);
  endtask

  initial begin
    n_pulse = 0; t0 = 0; t_valid = 0; t_fault = 0; last_code = '0;
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    check_outputs();
    @(negedge clock);
    clear = 1'b0;

    // Clean press on key 3
    n_pulse = 0; t_valid = 0; t0 = cyc + 1;
    hold(10'h008, 20);
    chk("clean_latency", t_valid - t0 + 1, 7);
    chk("clean_pulses", n_pulse, 1);
    chk("clean_code", last_code, 3);
    hold('0, 3);
    chk("release_busy_3", key_busy, 1);
    step('0);
    chk("release_idle_4", key_busy, 0);
    hold('0, 2);

    // Bounce on key 5
    n_pulse = 0;
    hold(10'h020, 2);
    step('0);
    chk("bounce_clrn_drop", db_clear_n, 0);
    hold(10'h020, 15);
    chk("bounce_pulses", n_pulse, 1);
    chk("bounce_code", last_code, 5);
    hold('0, 6);

    // Two keys at once, then key 0
    n_pulse = 0;
    hold(10'h003, 10);
    chk("multi_clrn", db_clear_n, 0);
    chk("multi_pulses", n_pulse, 0);
    hold(10'h001, 12);
    chk("multi_then_k0_pulses", n_pulse, 1);
    chk("multi_then_k0_code", last_code, 0);
    hold('0, 6);

    // Edge never arrives on key 9
    n_pulse = 0; t_fault = 0; t0 = cyc + 1; edge_en = 1'b0;
    hold(10'h200, 16);
    chk("timeout_latency", t_fault - t0 + 1, 13);
    chk("timeout_pulses", n_pulse, 0);
    edge_en = 1'b1;
    hold('0, 2);
    hold(10'h200, 12);
    chk("after_fault_pulses", n_pulse, 1);
    chk("after_fault_code", last_code, 9);
    chk("fault_sticky", db_fault, 1);
    hold('0, 6);

    // New key during HOLD is ignored
    n_pulse = 0;
    hold(10'h080, 9);
    hold('0, 2);
    hold(10'h004, 3);
    chk("hold_retrig_pulses", n_pulse, 1);
    chk("hold_retrig_code", last_code, 7);
    hold('0, 6);
    hold(10'h004, 12);
    chk("after_release_pulses", n_pulse, 2);
    chk("after_release_code", last_code, 2);
    hold('0, 6);

    // Random traffic: mostly single keys with random dwell, some bounces, multi-keys and lost edges
    for (int it = 0; it < 300; it++) begin
      logic [NK-1:0] k;
      int unsigned sel;
      sel = $urandom_range(0, 19);
      if (sel < 12)      k = NK'(1) << $urandom_range(0, NK - 1);
      else if (sel < 15) k = '0;
      else if (sel < 18) k = (NK'(1) << $urandom_range(0, NK - 1)) | (NK'(1) << $urandom_range(0, NK - 1));
      else               k = NK'($urandom);
      edge_en = ($urandom_range(0, 7) != 0);
      hold(k, int'($urandom_range(1, 14)));
    end
    edge_en = 1'b1;
    hold('0, 6);

    // Asynchronous clear two cycles into ARM
    exp_fault = 1'b1;
    hold('0, 1);
    chk("pre_reset_fault", db_fault, 1);
    n_pulse = 0;
    hold(10'h010, 3);
    chk("mid_arm_clrn", db_clear_n, 1);
    @(negedge clock);
    #2 clear = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("mid_reset_pulses", n_pulse, 0);
    @(negedge clock);
    clear = 1'b0;
    hold('0, 8);
    chk("post_reset_pulses", n_pulse, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
